zbt_sample_packer: RTL
======================

Name: zbt_sample_packer

Overview:
- Downstream neighbour of the address calculator. Consumes its word address, done flag and record/playback mode, and drives the ZBT SRAM port.
- Record: packs three consecutive 12-bit audio samples into one 36-bit ZBT word and writes it at the current word address.
- Playback: reads the word at the current address and unpacks it back into three samples for the AC97 output path.

Parameters:
SAMPLE_W, 12, bits per audio sample
WORD_W, 36, ZBT data width; must equal 3*SAMPLE_W
ADDR_W, 19, ZBT word address width
READ_LATENCY, 2, clk cycles from zbt_addr presented (read) to zbt_rdata valid

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_song  in  1  one-cycle pulse; latch record_mode, clear slot/pack state
record_mode  in  1  1=record, 0=playback; sampled only on start_song
song_done  in  1  from address calculator; 1 = no further accesses
mem_address  in  ADDR_W  current word address from address calculator
sample_valid  in  1  one-cycle strobe per decimated sample (24 kHz rate)
sample_in  in  SAMPLE_W  record sample, valid with sample_valid
sample_out  out  SAMPLE_W  playback sample
sample_out_valid  out  1  one-cycle strobe with sample_out
zbt_addr  out  ADDR_W  SRAM address
zbt_we  out  1  write enable, one cycle per write
zbt_wdata  out  WORD_W  write data
zbt_rdata  in  WORD_W  read data, READ_LATENCY after read issue

Behaviour:
Reset values (reset=0, asynchronous):
- All outputs 0.
- Internal state: state=IDLE, slot=0, pack register=0, rec_mode=0.

States:
- IDLE: entered on reset and when song_done is 1 after the flush rules below have run. Ignores sample_valid.
- RUN: entered on start_song, from any state.
- FLUSH: one cycle, record mode only.

start_song:
- rec_mode <= record_mode; slot <= 0; pack <= 0; state <= RUN.
- Overrides any same-cycle sample_valid, which is dropped.
- Cancels an in-flight read; its data is discarded and no sample_out_valid fires for it.

Slot counter:
- 0,1,2 wrap, advanced on each accepted sample_valid in RUN.
- Field order is MSB-first: slot0 -> [35:24], slot1 -> [23:12], slot2 -> [11:0].

Record (rec_mode=1, RUN):
- On sample_valid at slot0, latch word address wa <= mem_address.
- Each sample_valid writes sample_in into its field.
- Cycle after the slot2 sample_valid: zbt_we=1 for exactly one cycle, zbt_addr=wa, zbt_wdata=packed word; then pack <= 0.
- If song_done rises while slot!=0: go to FLUSH, write the partial word at wa with unused fields 0, then IDLE.
- If song_done rises with slot=0: go straight to IDLE, no write.

Playback (rec_mode=0, RUN):
- On sample_valid at slot0 with song_done=0: zbt_addr <= mem_address, zbt_we=0.
- Capture zbt_rdata exactly READ_LATENCY cycles later into the hold register.
- Every accepted sample_valid (all slots) produces sample_out_valid exactly READ_LATENCY+1 cycles later.
- sample_out carries the field for that slot, taken from the hold register.
- sample_valid with song_done=1: sample_out=0 with sample_out_valid at the same latency (silence). No read issued.

Timing and arbitration:
- Max one ZBT access per cycle; write and read never coexist because mode is latched.
- zbt_addr holds its last value when idle.
- sample_valid spacing of at least READ_LATENCY+2 cycles is required. Closer spacing is unsupported; a bench assertion flags it.
- Address width: wa is taken verbatim, no arithmetic. Wrap-around is the address calculator's responsibility.
- Reset mid-write or mid-read: outputs return to 0 immediately; the pending access is abandoned.

Decomposition:
- Shared package: SAMPLE_W, WORD_W, ADDR_W, and the state encoding (IDLE, RUN, FLUSH).
- Package also holds slot field-index constants and the MSB-first slot-to-field mapping.
- One natural sub-module: zbt_read_pipe. A READ_LATENCY-deep valid/slot shift line that times rdata capture and sample_out_valid, with a flush input driven by start_song.

Test Plan:
1. Reset asserted mid-operation -> all outputs 0 asynchronously; no zbt_we after release until start_song.
2. Record, start_song, mem_address=240000, samples 0xABC, 0x123, 0x456 -> single zbt_we pulse, zbt_addr=240000, zbt_wdata=36'hABC123456.
3. Record, two samples 0x111, 0x222, then song_done=1 -> FLUSH write zbt_wdata=36'h111222000; return to IDLE; later sample_valid ignored.
4. Playback, mem_address=288000, zbt_rdata model returns 36'hFED654321 after 2 cycles -> sample_out 0xFED, 0x654, 0x321, each valid 3 cycles after its sample_valid.
5. Playback with song_done=1 -> no zbt read issued; sample_out=0 with sample_out_valid at latency 3.
6. start_song in the same cycle as a slot1 sample_valid and an in-flight read -> sample dropped, slot=0, no stale sample_out_valid.

Source files
------------

// File: rtl/zbt_sample_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zbt_sample_packer_pkg
// Purpose  : Shared widths, state encoding, read-tag type and the MSB-first
//            slot <-> field mapping for the ZBT sample packer.
// Revision : 1.0 - initial release
// ============================================================================
package zbt_sample_packer_pkg;

  localparam int SAMPLE_W     = 12;
  localparam int SLOTS        = 3;
  localparam int WORD_W       = SLOTS * SAMPLE_W;  // 36: three samples per word
  localparam int ADDR_W       = 19;
  localparam int READ_LATENCY = 2;

  // Slot numbers and the LSB of the field each slot owns (slot0 is the MSBs)
  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam int SLOT0_LSB = 2 * SAMPLE_W;  // [35:24]
  localparam int SLOT1_LSB = SAMPLE_W;      // [23:12]
  localparam int SLOT2_LSB = 0;             // [11:0]

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // One entry of the playback timing line: which slot, and whether it is silence
  typedef struct packed {
    logic       valid;
    logic       silent;
    logic [1:0] slot;
  } rd_tag_t;

  function automatic logic [SAMPLE_W-1:0] get_field(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        slot);
    case (slot)
      SLOT0:   return w[SLOT0_LSB +: SAMPLE_W];
      SLOT1:   return w[SLOT1_LSB +: SAMPLE_W];
      default: return w[SLOT2_LSB +: SAMPLE_W];
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] put_field(input logic [WORD_W-1:0]   w,
                                                  input logic [1:0]          slot,
                                                  input logic [SAMPLE_W-1:0] s);
    logic [WORD_W-1:0] r;
    r = w;
    case (slot)
      SLOT0:   r[SLOT0_LSB +: SAMPLE_W] = s;
      SLOT1:   r[SLOT1_LSB +: SAMPLE_W] = s;
      default: r[SLOT2_LSB +: SAMPLE_W] = s;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zbt_sample_packer_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : zbt_read_pipe
// Purpose  : Shift line that follows each accepted playback sample. Stage
//            LATENCY-1 marks the edge where zbt_rdata is captured; stage
//            LATENCY marks the edge where sample_out is launched. A flush
//            kills every in-flight entry, including the ones due this edge.
// Revision : 1.0 - initial release
// ============================================================================
module zbt_read_pipe
  import zbt_sample_packer_pkg::*;
#(
  parameter int LATENCY = READ_LATENCY
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  rd_tag_t tag_in,
  output logic    capture,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [0:LATENCY];
  rd_tag_t stage_d [0:LATENCY];

  // Next state of the line: shift by one, or clear everything on flush
  always_comb begin
    for (int i = 0; i <= LATENCY; i++) stage_d[i] = '0;
    if (!flush) begin
      stage_d[0] = tag_in;
      for (int i = 1; i <= LATENCY; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= LATENCY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i <= LATENCY; i++) stage_q[i] <= stage_d[i];
    end
  end

  // Only a real slot0 read returns data worth keeping
  assign capture = !flush && stage_q[LATENCY-1].valid && !stage_q[LATENCY-1].silent
                   && (stage_q[LATENCY-1].slot == SLOT0);
  assign tag_out = flush ? '0 : stage_q[LATENCY];

endmodule
`default_nettype wire

// File: rtl/zbt_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : zbt_sample_packer
// Purpose  : Packs three 12-bit record samples into one 36-bit ZBT write, or
//            reads one ZBT word per three playback samples and unpacks it.
//            Playback keeps running after song_done, emitting silence strobes
//            so the AC97 path keeps its cadence; record flushes and idles.
// Revision : 1.0 - initial release
// ============================================================================
module zbt_sample_packer
  import zbt_sample_packer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start_song,
  input  logic                record_mode,
  input  logic                song_done,
  input  logic [ADDR_W-1:0]   mem_address,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic [ADDR_W-1:0]   zbt_addr,
  output logic                zbt_we,
  output logic [WORD_W-1:0]   zbt_wdata,
  input  logic [WORD_W-1:0]   zbt_rdata
);

  state_e              state_q, state_d;
  logic                rec_mode_q, rec_mode_d;
  logic [1:0]          slot_q, slot_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                sample_out_valid_q, sample_out_valid_d;
  logic [ADDR_W-1:0]   zbt_addr_q, zbt_addr_d;
  logic                zbt_we_q, zbt_we_d;
  logic [WORD_W-1:0]   zbt_wdata_q, zbt_wdata_d;

  rd_tag_t             tag_in;
  rd_tag_t             tag_out;
  logic                capture;
  logic [WORD_W-1:0]   packed_word;

  zbt_read_pipe #(.LATENCY(READ_LATENCY)) u_read_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (start_song),
    .tag_in  (tag_in),
    .capture (capture),
    .tag_out (tag_out)
  );

  // Next-state logic: start_song overrides everything, then per-mode sequencing
  always_comb begin
    state_d            = state_q;
    rec_mode_d         = rec_mode_q;
    slot_d             = slot_q;
    pack_d             = pack_q;
    wa_d               = wa_q;
    hold_d             = capture ? zbt_rdata : hold_q;
    zbt_addr_d         = zbt_addr_q;
    zbt_we_d           = 1'b0;
    zbt_wdata_d        = zbt_wdata_q;
    tag_in             = '0;
    packed_word        = put_field(pack_q, slot_q, sample_in);
    sample_out_valid_d = tag_out.valid;
    sample_out_d       = sample_out_q;
    if (tag_out.valid) begin
      sample_out_d = tag_out.silent ? '0 : get_field(hold_q, tag_out.slot);
    end

    if (start_song) begin
      rec_mode_d = record_mode;
      slot_d     = SLOT0;
      pack_d     = '0;
      state_d    = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (rec_mode_q) begin
            if (song_done) begin
              // Write out whatever partial word exists, unused fields already 0
              slot_d = SLOT0;
              pack_d = '0;
              if (slot_q != SLOT0) begin
                state_d     = ST_FLUSH;
                zbt_we_d    = 1'b1;
                zbt_addr_d  = wa_q;
                zbt_wdata_d = pack_q;
              end else begin
                state_d = ST_IDLE;
              end
            end else if (sample_valid) begin
              if (slot_q == SLOT0) wa_d = mem_address;
              if (slot_q == SLOT2) begin
                zbt_we_d    = 1'b1;
                zbt_addr_d  = wa_q;
                zbt_wdata_d = packed_word;
                pack_d      = '0;
                slot_d      = SLOT0;
              end else begin
                pack_d = packed_word;
                slot_d = slot_q + 2'd1;
              end
            end
          end else if (sample_valid) begin
            tag_in.valid  = 1'b1;
            tag_in.silent = song_done;
            tag_in.slot   = slot_q;
            if ((slot_q == SLOT0) && !song_done) zbt_addr_d = mem_address;
            slot_d = (slot_q == SLOT2) ? SLOT0 : slot_q + 2'd1;
          end
        end
        ST_FLUSH: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      rec_mode_q         <= 1'b0;
      slot_q             <= SLOT0;
      pack_q             <= '0;
      wa_q               <= '0;
      hold_q             <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      zbt_addr_q         <= '0;
      zbt_we_q           <= 1'b0;
      zbt_wdata_q        <= '0;
    end else begin
      state_q            <= state_d;
      rec_mode_q         <= rec_mode_d;
      slot_q             <= slot_d;
      pack_q             <= pack_d;
      wa_q               <= wa_d;
      hold_q             <= hold_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      zbt_addr_q         <= zbt_addr_d;
      zbt_we_q           <= zbt_we_d;
      zbt_wdata_q        <= zbt_wdata_d;
    end
  end

  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign zbt_addr         = zbt_addr_q;
  assign zbt_we           = zbt_we_q;
  assign zbt_wdata        = zbt_wdata_q;

endmodule
`default_nettype wire
